// File: rtl/inst_rom_loadable_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_loadable_pkg
//   Shared definitions for the loadable instruction memory:
//   - default geometry (DefaultDepth words, DefaultAddrW word-index bits)
//   - ROM FSM state encodings (RomIdle, RomLoad, RomRun), 2 bits wide
//   - instruction bus types and the NOP word returned when nothing is fetched
//   - fetch address legality helper
// -----------------------------------------------------------------------------
package inst_rom_loadable_pkg;

  localparam int DefaultDepth = 1024;
  localparam int DefaultAddrW = 10;

  localparam logic [1:0] RomIdle = 2'd0;
  localparam logic [1:0] RomLoad = 2'd1;
  localparam logic [1:0] RomRun  = 2'd2;

  typedef logic [31:0] InstBus;
  typedef logic [31:0] InstAddrBus;

  localparam InstBus ZeroWord = 32'h0000_0000;

  // A fetch address is legal when word aligned and inside the DEPTH*4 byte window
  // (every bit above the word index must be zero).
  function automatic logic fetch_addr_ok(input InstAddrBus a, input int unsigned addr_w);
    return (a[1:0] == 2'b00) && ((a >> (addr_w + 32'd2)) == 32'd0);
  endfunction

endpackage

// File: rtl/inst_rom_loadable.sv
// -----------------------------------------------------------------------------
// inst_rom_loadable
//   Instruction-fetch responder backed by a word-addressed memory that is filled
//   at run time through a streaming loader port. Fetches return NOPs until a
//   complete image has been loaded.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   ce          fetch enable from the core
//   addr        fetch byte address (PC)
//   inst        fetched instruction (combinational)
//   addr_err    fetch address misaligned / out of range (combinational)
//   load_start  one-cycle request to begin (re)loading an image
//   load_len    image length in words, sampled with load_start
//   load_valid  load_data is valid
//   load_data   image word, stored unmodified
//   load_ready  loader accepts a word this cycle (combinational)
//   load_done   one-cycle pulse after the image is complete (registered)
// -----------------------------------------------------------------------------
module inst_rom_loadable
  import inst_rom_loadable_pkg::*;
#(
  parameter int DEPTH  = DefaultDepth,
  parameter int ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  InstAddrBus        addr,
  output InstBus            inst,
  output logic              addr_err,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              load_done
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] PtrZero = (ADDR_W + 1)'(0);

  logic [1:0]      state_q, state_d;
  // One bit wider than the word index so a full DEPTH-word image ends at DEPTH
  // without wrapping.
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            done_q, done_d;

  logic [ADDR_W:0] start_len_s;
  logic            wr_en_s;
  logic            fetch_ok_s;

  InstBus mem [DEPTH];

  // Requested lengths beyond the array size are clamped.
  assign start_len_s = (load_len > DepthW) ? DepthW : load_len;
  assign fetch_ok_s  = fetch_addr_ok(addr, ADDR_W);

  // Loader FSM next-state: load_start wins over a word handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    len_d   = len_q;
    done_d  = 1'b0;
    wr_en_s = 1'b0;
    if (load_start) begin
      wptr_d = PtrZero;
      len_d  = start_len_s;
      if (start_len_s == PtrZero) begin
        // Empty image: nothing to stream, go straight to serving fetches.
        state_d = RomRun;
        done_d  = 1'b1;
      end else begin
        state_d = RomLoad;
      end
    end else begin
      case (state_q)
        RomLoad: begin
          if (load_valid) begin
            wr_en_s = 1'b1;
            wptr_d  = wptr_q + PtrOne;
            if (wptr_q == len_q - PtrOne) begin
              state_d = RomRun;
              done_d  = 1'b1;
            end else begin
              state_d = RomLoad;
            end
          end else begin
            state_d = RomLoad;
          end
        end
        RomIdle: state_d = RomIdle;
        RomRun:  state_d = RomRun;
        default: state_d = RomIdle;
      endcase
    end
  end

  // Loader FSM state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RomIdle;
      wptr_q  <= PtrZero;
      len_q   <= PtrZero;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // Image memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem[wptr_q[ADDR_W-1:0]] <= load_data;
    end
  end

  // Combinational fetch path: only a completed image is ever visible.
  always_comb begin
    inst     = ZeroWord;
    addr_err = 1'b0;
    if (state_q == RomRun && ce) begin
      if (fetch_ok_s) begin
        inst = mem[addr[ADDR_W+1:2]];
      end else begin
        addr_err = 1'b1;
      end
    end else begin
      inst     = ZeroWord;
      addr_err = 1'b0;
    end
  end

  assign load_ready = (state_q == RomLoad);
  assign load_done  = done_q;

endmodule

// File: tb/tb_inst_rom_loadable.sv
module tb_inst_rom_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        addr_err;
  logic        load_start;
  logic [10:0] load_len;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  typedef struct {
    string       name;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[8];

  inst_rom_loadable dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .addr       (addr),
    .inst       (inst),
    .addr_err   (addr_err),
    .load_start (load_start),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one fetch; expectation goes through the scoreboard queue.
  task automatic fetch(input string nm, input logic c, input logic [31:0] a,
                       input logic [31:0] ei, input logic ee);
    exp_t e;
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
    ce   = c;
    addr = a;
    e.name = nm; e.inst = ei; e.err = ee;
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    chk({e.name, ".inst"}, inst, e.inst);
    chk({e.name, ".err"}, {31'd0, addr_err}, {31'd0, e.err});
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    ce         = 1'b0;
    load_start = 1'b1;
    load_len   = 11'(len);
    load_valid = 1'b0;
  endtask

  task automatic send(input logic v, input logic [31:0] d, output bit acc, output bit rdy);
    @(negedge clk);
    load_start = 1'b0;
    load_valid = v;
    load_data  = d;
    #1;
    rdy = load_ready;
    acc = v && load_ready;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] w[3];
    logic [31:0] g[3];
    logic [31:0] r[4];
    logic        pat[5];
    bit acc, rdy;
    int n_acc, n_rdy, d0, gi;

    w[0] = 32'h3401_1100; w[1] = 32'h3402_0020; w[2] = 32'h3403_ff00;
    g[0] = 32'h1111_0001; g[1] = 32'h2222_0002; g[2] = 32'h3333_0003;
    r[0] = 32'hC0DE_0000; r[1] = 32'hC0DE_0001; r[2] = 32'hC0DE_0002; r[3] = 32'hC0DE_0003;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;

    vecs[0] = '{"w0",       1'b1, 32'h0000_0000, 32'h3401_1100, 1'b0};
    vecs[1] = '{"w1",       1'b1, 32'h0000_0004, 32'h3402_0020, 1'b0};
    vecs[2] = '{"w2",       1'b1, 32'h0000_0008, 32'h3403_ff00, 1'b0};
    vecs[3] = '{"misalign", 1'b1, 32'h0000_0002, 32'h0000_0000, 1'b1};
    vecs[4] = '{"oor",      1'b1, 32'h0000_1000, 32'h0000_0000, 1'b1};
    vecs[5] = '{"ce0_bad",  1'b0, 32'h0000_1001, 32'h0000_0000, 1'b0};
    vecs[6] = '{"high",     1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[7] = '{"last_ok",  1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b0};

    rst = 1'b1; ce = 1'b0; addr = 32'd0; load_start = 1'b0;
    load_len = 11'd0; load_valid = 1'b0; load_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    fetch("rst_fetch", 1'b1, 32'h0, 32'h0, 1'b0);
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);

    // Back-to-back load of 3 words
    d0 = done_cnt;
    do_start(3);
    n_rdy = 0; n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, w[i], acc, rdy);
      n_rdy += int'(rdy); n_acc += int'(acc);
    end
    idle_cyc();
    chk("l3_done_pulse", {31'd0, load_done}, 32'd1);
    chk("l3_ready_off", {31'd0, load_ready}, 32'd0);
    chk("l3_ready_cycles", n_rdy, 32'd3);
    idle_cyc();
    chk("l3_done_once", done_cnt - d0, 32'd1);

    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].name, vecs[i].ce, vecs[i].addr, vecs[i].exp_inst, vecs[i].exp_err);
    end

    // Gapped valid 1,0,1,0,1 with len 3
    d0 = done_cnt;
    do_start(3);
    n_rdy = 0; n_acc = 0; gi = 0;
    for (int i = 0; i < 5; i++) begin
      send(pat[i], pat[i] ? g[gi] : 32'hDEAD_BEEF, acc, rdy);
      n_rdy += int'(rdy); n_acc += int'(acc);
      if (acc) gi++;
      if (i < 4) chk($sformatf("gap_no_done_%0d", i), done_cnt - d0, 32'd0);
    end
    idle_cyc();
    chk("gap_acc", n_acc, 32'd3);
    chk("gap_ready", n_rdy, 32'd5);
    chk("gap_done", {31'd0, load_done}, 32'd1);
    chk("gap_ready_off", {31'd0, load_ready}, 32'd0);
    fetch("gap_w0", 1'b1, 32'h0, g[0], 1'b0);
    fetch("gap_w1", 1'b1, 32'h4, g[1], 1'b0);
    fetch("gap_w2", 1'b1, 32'h8, g[2], 1'b0);

    // Reset after 2 of 4 words, then full reload
    do_start(4);
    send(1'b1, 32'hBAD0_0000, acc, rdy);
    send(1'b1, 32'hBAD0_0001, acc, rdy);
    @(negedge clk);
    load_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fetch("midrst_fetch", 1'b1, 32'h0, 32'h0, 1'b0);
    chk("midrst_ready", {31'd0, load_ready}, 32'd0);
    d0 = done_cnt;
    do_start(4);
    for (int i = 0; i < 4; i++) send(1'b1, r[i], acc, rdy);
    idle_cyc();
    chk("reload_done", {31'd0, load_done}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      fetch($sformatf("reload_w%0d", i), 1'b1, 32'(i * 4), r[i], 1'b0);
    end

    // Zero-length reload from RUN
    d0 = done_cnt;
    do_start(0);
    idle_cyc();
    chk("len0_done", {31'd0, load_done}, 32'd1);
    chk("len0_ready", {31'd0, load_ready}, 32'd0);
    fetch("len0_keep0", 1'b1, 32'h0, r[0], 1'b0);
    fetch("len0_keep3", 1'b1, 32'hC, r[3], 1'b0);
    chk("len0_done_once", done_cnt - d0, 32'd1);

    // Oversize length is clamped to the array depth
    d0 = done_cnt;
    do_start(2000);
    n_acc = 0;
    for (int i = 0; i < 1100; i++) begin
      send(1'b1, 32'hA500_0000 ^ 32'(i), acc, rdy);
      n_acc += int'(acc);
    end
    idle_cyc();
    chk("clamp_acc", n_acc, 32'd1024);
    chk("clamp_done_once", done_cnt - d0, 32'd1);
    fetch("clamp_first", 1'b1, 32'h0, 32'hA500_0000, 1'b0);
    fetch("clamp_mid",   1'b1, 32'h800, 32'hA500_0200, 1'b0);
    fetch("clamp_last",  1'b1, 32'hFFC, 32'hA500_03FF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
